// File: rtl/unidade_acesso_mem_pkg.sv
// Shared definitions for the load/store unit: access size encodings,
// FSM state type, byte lane width and the request legality check.
package pkg_acesso_mem;

  localparam int LARG_FAIXA = 8;

  localparam logic [1:0] TAM_PALAVRA   = 2'b00;
  localparam logic [1:0] TAM_MEIA      = 2'b01;
  localparam logic [1:0] TAM_BYTE      = 2'b10;
  localparam logic [1:0] TAM_RESERVADO = 2'b11;

  typedef enum logic [1:0] {
    OCIOSO   = 2'b00,
    LER      = 2'b01,
    ESCREVER = 2'b10,
    RESP     = 2'b11
  } estado_t;

  // A request is illegal when its size is reserved or its byte offset is
  // not a multiple of the access size.
  function automatic logic pedido_invalido(input logic [1:0] tamanho,
                                           input logic [1:0] offset);
    logic inval;
    inval = 1'b0;
    case (tamanho)
      TAM_PALAVRA: inval = (offset != 2'b00);
      TAM_MEIA:    inval = offset[0];
      TAM_BYTE:    inval = 1'b0;
      default:     inval = 1'b1;
    endcase
    return inval;
  endfunction

endpackage

// File: rtl/unidade_acesso_mem_alinhador.sv
// Combinational byte-lane steering: extracts and extends the loaded field,
// and merges sub-word store data into the previously read word.
module alinhador_dados
  import pkg_acesso_mem::*;
(
  input  logic [1:0]  tamanho_i,
  input  logic        sinal_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] leitura_i,
  input  logic [31:0] dado_i,
  output logic [31:0] carga_o,
  output logic [31:0] escrita_o
);

  logic [4:0]  deslocamento;
  logic [31:0] alinhado;
  logic [7:0]  campo_byte;
  logic [15:0] campo_meia;
  logic [31:0] mascara_byte;
  logic [31:0] mascara_meia;

  // Lane position in bits and the lane-aligned view of the read word.
  always_comb begin
    deslocamento = {offset_i, 3'b000};
    alinhado     = leitura_i >> deslocamento;
    campo_byte   = alinhado[7:0];
    campo_meia   = alinhado[15:0];
    mascara_byte = 32'h0000_00FF << deslocamento;
    mascara_meia = 32'h0000_FFFF << deslocamento;
  end

  // Load result: selected field, sign- or zero-extended; words pass through.
  always_comb begin
    carga_o = leitura_i;
    case (tamanho_i)
      TAM_BYTE: carga_o = {{24{sinal_i & campo_byte[7]}}, campo_byte};
      TAM_MEIA: carga_o = {{16{sinal_i & campo_meia[15]}}, campo_meia};
      default:  carga_o = leitura_i;
    endcase
  end

  // Store data: replace only the addressed lanes of the read word.
  always_comb begin
    escrita_o = dado_i;
    case (tamanho_i)
      TAM_BYTE: escrita_o = (leitura_i & ~mascara_byte) |
                            ({24'h0, dado_i[7:0]} << deslocamento);
      TAM_MEIA: escrita_o = (leitura_i & ~mascara_meia) |
                            ({16'h0, dado_i[15:0]} << deslocamento);
      default:  escrita_o = dado_i;
    endcase
  end

endmodule

// File: rtl/unidade_acesso_mem.sv
// Load/store initiator for a 256-word combinational-read data memory.
// Handshake: a request transfers on a rising edge where ReqValido and
// ReqPronto are both high; ReqPronto depends only on the FSM state, the
// requester must hold ReqValido and its fields until that edge, and the
// single-cycle RespValido pulse cannot be stalled.
module unidade_acesso_mem
  import pkg_acesso_mem::*;
#(
  parameter int LARG_END_PAL = 8,
  parameter int LARG_DADO    = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ReqValido,
  output logic                    ReqPronto,
  input  logic                    ReqEscrita,
  input  logic [1:0]              ReqTamanho,
  input  logic                    ReqSinal,
  input  logic [LARG_END_PAL+1:0] ReqEndereco,
  input  logic [LARG_DADO-1:0]    ReqDado,
  output logic                    RespValido,
  output logic [LARG_DADO-1:0]    RespDado,
  output logic                    RespErro,
  output logic [LARG_END_PAL-1:0] EndLeitura,
  output logic [LARG_END_PAL-1:0] EndEscrita,
  output logic [LARG_DADO-1:0]    DadoMemEscrita,
  output logic                    CTRLEscritaMem,
  input  logic [LARG_DADO-1:0]    DadoMemoria,
  output estado_t                 EstadoDepuracao
);

  estado_t                 estado_q, estado_d;
  logic                    escrita_q, escrita_d;
  logic [1:0]              tamanho_q, tamanho_d;
  logic                    sinal_q, sinal_d;
  logic [LARG_END_PAL+1:0] endereco_q, endereco_d;
  logic [LARG_DADO-1:0]    dado_q, dado_d;
  logic [LARG_DADO-1:0]    leitura_q, leitura_d;
  logic                    erro_q, erro_d;

  logic [LARG_DADO-1:0]    carga;
  logic [LARG_DADO-1:0]    mesclado;

  alinhador_dados u_alinhador (
    .tamanho_i (tamanho_q),
    .sinal_i   (sinal_q),
    .offset_i  (endereco_q[1:0]),
    .leitura_i (leitura_q),
    .dado_i    (dado_q),
    .carga_o   (carga),
    .escrita_o (mesclado)
  );

  // State and latched request registers; reset clears everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      estado_q   <= OCIOSO;
      escrita_q  <= 1'b0;
      tamanho_q  <= 2'b00;
      sinal_q    <= 1'b0;
      endereco_q <= '0;
      dado_q     <= '0;
      leitura_q  <= '0;
      erro_q     <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      escrita_q  <= escrita_d;
      tamanho_q  <= tamanho_d;
      sinal_q    <= sinal_d;
      endereco_q <= endereco_d;
      dado_q     <= dado_d;
      leitura_q  <= leitura_d;
      erro_q     <= erro_d;
    end
  end

  // Next-state, request capture and handshake/write-enable outputs.
  always_comb begin
    estado_d       = estado_q;
    escrita_d      = escrita_q;
    tamanho_d      = tamanho_q;
    sinal_d        = sinal_q;
    endereco_d     = endereco_q;
    dado_d         = dado_q;
    leitura_d      = leitura_q;
    erro_d         = erro_q;
    ReqPronto      = 1'b0;
    RespValido     = 1'b0;
    CTRLEscritaMem = 1'b0;
    case (estado_q)
      OCIOSO: begin
        ReqPronto = 1'b1;
        if (ReqValido) begin
          escrita_d  = ReqEscrita;
          tamanho_d  = ReqTamanho;
          sinal_d    = ReqSinal;
          endereco_d = ReqEndereco;
          dado_d     = ReqDado;
          erro_d     = pedido_invalido(ReqTamanho, ReqEndereco[1:0]);
          if (erro_d)
            estado_d = RESP;
          else if (ReqEscrita && (ReqTamanho == TAM_PALAVRA))
            estado_d = ESCREVER;
          else
            estado_d = LER;
        end
      end
      LER: begin
        leitura_d = DadoMemoria;
        estado_d  = escrita_q ? ESCREVER : RESP;
      end
      ESCREVER: begin
        // A reset arriving in this cycle must not let the write through.
        CTRLEscritaMem = !RST;
        estado_d       = RESP;
      end
      RESP: begin
        RespValido = 1'b1;
        estado_d   = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // Datapath outputs: addresses always follow the latched word address;
  // response data is only non-zero for a successful load.
  always_comb begin
    EndLeitura      = endereco_q[LARG_END_PAL+1:2];
    EndEscrita      = endereco_q[LARG_END_PAL+1:2];
    DadoMemEscrita  = (estado_q == ESCREVER) ? mesclado : '0;
    RespErro        = RespValido && erro_q;
    RespDado        = (RespValido && !erro_q && !escrita_q) ? carga : '0;
    EstadoDepuracao = estado_q;
  end

endmodule

// File: tb/tb_unidade_acesso_mem.sv
// Bench for unidade_acesso_mem: behavioural memory, byte-level reference
// model, directed cases followed by randomized requests.
module tb_unidade_acesso_mem;
  import pkg_acesso_mem::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        ReqValido, ReqPronto, ReqEscrita, ReqSinal;
  logic [1:0]  ReqTamanho;
  logic [9:0]  ReqEndereco;
  logic [31:0] ReqDado;
  logic        RespValido, RespErro, CTRLEscritaMem;
  logic [31:0] RespDado, DadoMemEscrita, DadoMemoria;
  logic [7:0]  EndLeitura, EndEscrita;
  estado_t     estado_dbg;

  unidade_acesso_mem #(.LARG_END_PAL(8), .LARG_DADO(32)) dut (
    .CLK(clk), .RST(rst),
    .ReqValido(ReqValido), .ReqPronto(ReqPronto), .ReqEscrita(ReqEscrita),
    .ReqTamanho(ReqTamanho), .ReqSinal(ReqSinal), .ReqEndereco(ReqEndereco),
    .ReqDado(ReqDado), .RespValido(RespValido), .RespDado(RespDado),
    .RespErro(RespErro), .EndLeitura(EndLeitura), .EndEscrita(EndEscrita),
    .DadoMemEscrita(DadoMemEscrita), .CTRLEscritaMem(CTRLEscritaMem),
    .DadoMemoria(DadoMemoria), .EstadoDepuracao(estado_dbg)
  );

  // ---------------- memory attached to the DUT ----------------
  logic [31:0] mem [256];
  int wr_cnt = 0;
  assign DadoMemoria = mem[EndLeitura];
  always @(posedge clk) begin
    if (CTRLEscritaMem) begin
      mem[EndEscrita] <= DadoMemEscrita;
      wr_cnt = wr_cnt + 1;
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  ref_bytes [1024];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [7:0] w);
    int b;
    b = 4 * int'(w);
    return {ref_bytes[b+3], ref_bytes[b+2], ref_bytes[b+1], ref_bytes[b]};
  endfunction

  // Memory seen as a little-endian byte array; a request touches nb bytes.
  task automatic model(input logic esc, input logic [1:0] tam, input logic sn,
                       input logic [9:0] a, input logic [31:0] d,
                       output logic err, output int lat, output int nwr);
    int nb;
    logic [31:0] v;
    nb  = (tam == 2'd0) ? 4 : (tam == 2'd1) ? 2 : 1;
    err = (tam == 2'd3) || ((int'(a) % nb) != 0);
    nwr = 0;
    if (err) begin
      lat = 1;
      exp_q.push_back(32'h0);
    end else if (esc) begin
      for (int i = 0; i < nb; i++) ref_bytes[int'(a) + i] = 8'(d >> (8 * i));
      lat = (nb == 4) ? 2 : 3;
      nwr = 1;
      exp_q.push_back(32'h0);
    end else begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v = v | (32'(ref_bytes[int'(a) + i]) << (8 * i));
      if (sn && nb < 4 && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      lat = 2;
      exp_q.push_back(v);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic req(input logic esc, input logic [1:0] tam, input logic sn,
                     input logic [9:0] a, input logic [31:0] d);
    logic err;
    int lat, nwr, w0, guard, got_lat;
    logic [31:0] e;
    @(negedge clk);
    ReqEscrita = esc; ReqTamanho = tam; ReqSinal = sn; ReqEndereco = a; ReqDado = d;
    ReqValido = 1'b1;
    guard = 0;
    while (!ReqPronto && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("pronto_aceite", {31'b0, ReqPronto}, 32'h1);
    w0 = wr_cnt;
    model(esc, tam, sn, a, d, err, lat, nwr);
    @(negedge clk);
    ReqValido = 1'b0;
    got_lat = 1;
    if (!err && !(esc && tam == TAM_PALAVRA))
      chk("end_leitura", {24'h0, EndLeitura}, {24'h0, a[9:2]});
    while (!RespValido && got_lat < 8) begin
      @(negedge clk);
      got_lat++;
    end
    chk("latencia", 32'(got_lat), 32'(lat));
    e = exp_q.pop_front();
    chk("resp_dado", RespDado, e);
    chk("resp_erro", {31'b0, RespErro}, {31'b0, err});
    @(negedge clk);
    chk("pronto_pos", {31'b0, ReqPronto}, 32'h1);
    chk("pulso_unico", {31'b0, RespValido}, 32'h0);
    chk("n_escritas", 32'(wr_cnt - w0), 32'(nwr));
    chk("mem_palavra", mem[a[9:2]], ref_word(a[9:2]));
  endtask

  task automatic reset_em_escrita();
    int w0;
    logic [31:0] antes;
    @(negedge clk);
    ReqEscrita = 1'b1; ReqTamanho = TAM_PALAVRA; ReqSinal = 1'b0;
    ReqEndereco = 10'h020; ReqDado = 32'hCAFE_F00D; ReqValido = 1'b1;
    w0 = wr_cnt;
    antes = mem[8];
    @(negedge clk);
    ReqValido = 1'b0;
    chk("rst_estado_escrever", {30'b0, estado_dbg}, {30'b0, ESCREVER});
    rst = 1'b1;
    #1;
    chk("rst_we_suprimido", {31'b0, CTRLEscritaMem}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_pronto", {31'b0, ReqPronto}, 32'h1);
    chk("rst_sem_resp_a", {31'b0, RespValido}, 32'h0);
    @(negedge clk);
    chk("rst_sem_resp_b", {31'b0, RespValido}, 32'h0);
    chk("rst_sem_escrita", 32'(wr_cnt - w0), 32'h0);
    chk("rst_mem_intacta", mem[8], antes);
  endtask

  task automatic back_to_back();
    logic [9:0] addrs [4];
    logic err, e_err;
    int lat, nwr, idx, nresp, cyc, last;
    logic [31:0] e;
    addrs[0] = 10'h000; addrs[1] = 10'h004; addrs[2] = 10'h008; addrs[3] = 10'h3FC;
    e_err = 1'b0;
    for (int i = 0; i < 4; i++) model(1'b0, TAM_PALAVRA, 1'b0, addrs[i], 32'h0, err, lat, nwr);
    @(negedge clk);
    ReqEscrita = 1'b0; ReqTamanho = TAM_PALAVRA; ReqSinal = 1'b0; ReqDado = 32'h0;
    ReqEndereco = addrs[0]; ReqValido = 1'b1;
    idx = 0; nresp = 0; cyc = 0; last = 0;
    while (nresp < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (RespValido) begin
        e = exp_q.pop_front();
        chk("b2b_dado", RespDado, e);
        chk("b2b_erro", {31'b0, RespErro}, {31'b0, e_err});
        if (nresp > 0) chk("b2b_intervalo", 32'(cyc - last), 32'd3);
        last = cyc;
        nresp++;
        idx++;
        if (idx < 4) ReqEndereco = addrs[idx];
        else ReqValido = 1'b0;
      end else if (!ReqPronto) begin
        chk("b2b_end_leitura", {24'h0, EndLeitura}, {24'h0, addrs[idx][9:2]});
      end
    end
    ReqValido = 1'b0;
    chk("b2b_respostas", 32'(nresp), 32'd4);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [9:0] a;
    rst = 1'b1;
    ReqValido = 1'b0; ReqEscrita = 1'b0; ReqTamanho = 2'b00; ReqSinal = 1'b0;
    ReqEndereco = '0; ReqDado = '0;
    for (int w = 0; w < 256; w++) begin
      mem[w] = $urandom;
      for (int b = 0; b < 4; b++) ref_bytes[4 * w + b] = 8'(mem[w] >> (8 * b));
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_pronto", {31'b0, ReqPronto}, 32'h1);
    chk("reset_resp_valido", {31'b0, RespValido}, 32'h0);
    chk("reset_resp_erro", {31'b0, RespErro}, 32'h0);
    chk("reset_resp_dado", RespDado, 32'h0);
    chk("reset_we", {31'b0, CTRLEscritaMem}, 32'h0);
    chk("reset_end_leitura", {24'h0, EndLeitura}, 32'h0);
    chk("reset_end_escrita", {24'h0, EndEscrita}, 32'h0);
    chk("reset_dado_escrita", DadoMemEscrita, 32'h0);

    // word store / load
    req(1'b1, TAM_PALAVRA, 1'b0, 10'h010, 32'hDEAD_BEEF);
    chk("palavra_mem", mem[4], 32'hDEAD_BEEF);
    req(1'b0, TAM_PALAVRA, 1'b0, 10'h010, 32'h0);
    // byte store over 0x11223344, signed and unsigned reload
    req(1'b1, TAM_PALAVRA, 1'b0, 10'h010, 32'h1122_3344);
    req(1'b1, TAM_BYTE, 1'b0, 10'h013, 32'h0000_0080);
    chk("byte_mescla", mem[4], 32'h8022_3344);
    req(1'b0, TAM_BYTE, 1'b1, 10'h013, 32'h0);
    req(1'b0, TAM_BYTE, 1'b0, 10'h013, 32'h0);
    // half store over zero, signed reload
    req(1'b1, TAM_PALAVRA, 1'b0, 10'h00C, 32'h0);
    req(1'b1, TAM_MEIA, 1'b0, 10'h00E, 32'h0000_ABCD);
    chk("meia_mescla", mem[3], 32'hABCD_0000);
    req(1'b0, TAM_MEIA, 1'b1, 10'h00E, 32'h0);
    // misaligned and reserved size
    req(1'b0, TAM_PALAVRA, 1'b0, 10'h001, 32'h0);
    req(1'b1, TAM_MEIA, 1'b0, 10'h003, 32'h0000_1234);
    req(1'b0, TAM_RESERVADO, 1'b0, 10'h020, 32'h0);
    // reset during the write cycle
    reset_em_escrita();
    // back-to-back loads
    back_to_back();
    // randomized traffic, mostly in a small window to hit recent writes
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) != 0) a = 10'($urandom_range(0, 63));
      else a = 10'($urandom_range(0, 1023));
      req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          a, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/unidade_acesso_mem.md
Name: unidade_acesso_mem

Overview:
Load/store initiator for the main data memory (32-bit words, 256-word array, combinational read, write on CLK rising edge). It accepts one byte-addressed CPU request at a time through a valid/ready handshake and drives the memory's read/write address, write data and write-enable signals. It provides ARM-style byte, halfword and word access with optional sign extension. Sub-word stores use read-modify-write.

Parameters:
LARG_END_PAL, 8, word-address width (memory depth 2^8 words)
LARG_DADO, 32, data width; fixed at 32 (4 byte lanes)

Ports:
CLK  in  1  system clock, all state on rising edge
RST  in  1  synchronous, active-high reset
ReqValido  in  1  request present
ReqPronto  out  1  unit can accept a request (high only in OCIOSO)
ReqEscrita  in  1  1 = store, 0 = load
ReqTamanho  in  2  00 word, 01 halfword, 10 byte, 11 reserved
ReqSinal  in  1  load only: 1 = sign-extend, 0 = zero-extend
ReqEndereco  in  10  byte address {word[7:0], offset[1:0]}
ReqDado  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
RespValido  out  1  one-cycle pulse, request complete
RespDado  out  32  load result, extended; 0 for stores/errors
RespErro  out  1  valid with RespValido: misaligned or reserved size
EndLeitura  out  8  memory read word address
EndEscrita  out  8  memory write word address
DadoMemEscrita  out  32  memory write data
CTRLEscritaMem  out  1  memory write enable
DadoMemoria  in  32  memory read data (combinational from EndLeitura)

Behaviour:
- Clock is CLK. Reset is synchronous and active-high on RST. RST has priority over everything.
- Reset values: state OCIOSO; RespValido, RespErro, CTRLEscritaMem = 0; RespDado, DadoMemEscrita, latched request = 0; EndLeitura and EndEscrita = 0.
- States: OCIOSO, LER, ESCREVER, RESP.
- OCIOSO: ReqPronto = 1. A request is accepted when ReqValido && ReqPronto. On accept, all Req* inputs are latched. Next state:
  - error (word with offset != 0, half with offset[0] = 1, or size 11) -> RESP with error flagged, no memory access.
  - word store -> ESCREVER.
  - any load, or sub-word store -> LER.
- LER: EndLeitura = latched word address. DadoMemoria is captured into the read register. Load -> RESP. Sub-word store -> ESCREVER.
- ESCREVER: CTRLEscritaMem = 1 and EndEscrita = latched word address. The memory writes at the end of this cycle. Write data:
  - word store: ReqDado.
  - byte store: read register with lane offset replaced by ReqDado[7:0].
  - half store: lanes {offset+1, offset} replaced by ReqDado[15:0].
  - Next state: RESP.
- RESP: RespValido = 1 for exactly one cycle, then OCIOSO. There is no response backpressure.
- Load data formation (little-endian lanes): byte = rd[8*off+7 : 8*off]; half = rd[8*off+15 : 8*off].
  - Sign extension takes the MSB of the selected field when ReqSinal = 1, otherwise zero-extend.
  - A word load returns rd unchanged, and ReqSinal is ignored.
- ReqSinal is ignored for stores.
- Latency, with accept at cycle T, RespValido is high in:
  - error: T+1
  - word store: T+2
  - load: T+2
  - sub-word store: T+3
- Next accept is possible the cycle after RespValido, giving back-to-back throughput.
- CTRLEscritaMem = (state == ESCREVER) && !RST. If RST is high during ESCREVER, the write is suppressed. Reset in any other state aborts the operation with no response and no memory write.
- EndLeitura and EndEscrita both hold the latched word address outside reset. Word address 255 has no wrap issue because the address is exactly 8 bits.
- ReqValido while not in OCIOSO is ignored; the requester must hold it until it sees ReqPronto.

Decomposition:
- Package pkg_acesso_mem holds:
  - size encodings TAM_PALAVRA, TAM_MEIA, TAM_BYTE.
  - state enum (OCIOSO, LER, ESCREVER, RESP).
  - lane width constant.
- Sub-module alinhador_dados (combinational) holds load lane extract/extend and store lane merge. The FSM stays in the top module.

Test Plan:
- Word store 0xDEADBEEF at byte address 0x010, then word load from 0x010 -> store RespValido at T+2; load returns 0xDEADBEEF with RespErro = 0; memory word 4 written once.
- Byte store 0x80 to address 0x013 over word 0x11223344, then signed byte load at 0x013 -> memory word becomes 0x80223344; load returns 0xFFFFFF80. Unsigned load returns 0x00000080.
- Half store 0xABCD at address 0x00E over 0x00000000, then signed half load at 0x00E -> word 3 = 0xABCD0000; load returns 0xFFFFABCD.
- Misalignment and reserved size:
  - word load at 0x001 -> RespErro = 1 at T+1, RespDado = 0, CTRLEscritaMem never asserted.
  - half store at 0x003 -> same error response, no write.
  - ReqTamanho = 11 -> same error response.
- RST asserted in the ESCREVER cycle of a word store -> CTRLEscritaMem = 0, memory unchanged, RespValido never pulses, ReqPronto = 1 the next cycle.
- ReqValido held high for 4 back-to-back word loads at 0x000, 0x004, 0x008, 0x3FC -> responses every 3 cycles in order; address 0x3FC drives EndLeitura = 0xFF.
